// File: rtl/slow_to_fast_pkg.sv
// Shared types and constants for the slow-to-fast bus synchroniser.
package slow_to_fast_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_NCH   = 1;
    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned PTR_W     = $clog2(DEF_DEPTH);
    localparam int unsigned CNT_W     = 16;

    // Sync chain and edge flop reset high so a real low->high is needed first.
    localparam logic SYNC_RST_VAL = 1'b1;

    typedef logic [DEF_NCH*DEF_WIDTH-1:0] data_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/slow_to_fast_bus_sync_sts_fifo.sv
// First-word fall-through FIFO (sts_fifo); a push is accepted when full if a pop happens in the same cycle.
module sts_fifo
    import slow_to_fast_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/slow_to_fast_bus_sync.sv
// Captures data_in on synchronised slow_clk_in rising edges into a FWFT FIFO in the fast_clk domain.
// Optional slow-period monitor enabled by defining SLOW_TO_FAST_PERIOD_MON_EN.
module slow_to_fast_bus_sync
    import slow_to_fast_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NCH         = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned MIN_RATIO   = 8
) (
    input  logic                 fast_clk,
    input  logic                 reset_n,
    input  logic                 slow_clk_in,
    input  logic [NCH*WIDTH-1:0] data_in,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 clr_err,
    output logic                 overflow,
    output logic                 too_fast
);

    localparam int unsigned DW = NCH * WIDTH;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   overflow_q, overflow_d;
    logic                   slow_edge;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   drop;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], slow_clk_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    assign slow_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Full is only relieved by a pop that the FIFO will actually honour this cycle.
    assign drop = slow_edge && fifo_full && !out_ready;

    always_comb begin
        overflow_d = overflow_q;
        if (clr_err) overflow_d = 1'b0;
        if (drop)    overflow_d = 1'b1;
    end

    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= {SYNC_STAGES{SYNC_RST_VAL}};
            prev_q     <= SYNC_RST_VAL;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign out_valid = !fifo_empty;

    sts_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (fast_clk),
        .rst_n (reset_n),
        .push  (slow_edge),
        .wdata (data_in),
        .pop   (out_ready),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef SLOW_TO_FAST_PERIOD_MON_EN
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic             too_fast_q, too_fast_d;

    always_comb begin
        per_cnt_d  = per_cnt_q;
        too_fast_d = too_fast_q;
        if (per_cnt_q != '1) per_cnt_d = per_cnt_q + CNT_W'(1);
        if (clr_err)         too_fast_d = 1'b0;
        if (slow_edge) begin
            per_cnt_d = '0;
            if (per_cnt_q < CNT_W'(MIN_RATIO)) too_fast_d = 1'b1;
        end
    end

    // Counter resets saturated so the first edge after reset never flags.
    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt_q  <= '1;
            too_fast_q <= 1'b0;
        end else begin
            per_cnt_q  <= per_cnt_d;
            too_fast_q <= too_fast_d;
        end
    end

    assign too_fast = too_fast_q;
`else
    assign too_fast = 1'b0;
`endif

endmodule

// File: tb/tb_slow_to_fast_bus_sync.sv
// Directed self-checking bench for slow_to_fast_bus_sync (WIDTH=8, NCH=2, SYNC_STAGES=2, DEPTH=4).
module tb_slow_to_fast_bus_sync;

    logic        fast_clk = 1'b0;
    logic        reset_n;
    logic        slow_clk_in;
    logic [15:0] data_in;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        clr_err;
    logic        overflow;
    logic        too_fast;

    int checks = 0;
    int errors = 0;

    always #5 fast_clk = ~fast_clk;

    slow_to_fast_bus_sync #(
        .WIDTH       (8),
        .NCH         (2),
        .SYNC_STAGES (2),
        .DEPTH       (4),
        .MIN_RATIO   (8)
    ) dut (
        .fast_clk    (fast_clk),
        .reset_n     (reset_n),
        .slow_clk_in (slow_clk_in),
        .data_in     (data_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .clr_err     (clr_err),
        .overflow    (overflow),
        .too_fast    (too_fast)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge fast_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One slow period of 8 fast cycles: 4 high, 4 low.
    task automatic slow_cycle(input logic [15:0] d);
        slow_clk_in = 1'b1;
        data_in     = d;
        tick(4);
        slow_clk_in = 1'b0;
        tick(4);
    endtask

    logic exp_tf;

    initial begin
        reset_n     = 1'b0;
        slow_clk_in = 1'b0;
        data_in     = '0;
        out_ready   = 1'b0;
        clr_err     = 1'b0;
        tick(2);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_too_fast", 32'(too_fast), 32'd0);
        reset_n = 1'b1;
        tick(4);

        // Test 1: latency and single word pass-through
        out_ready   = 1'b1;
        slow_clk_in = 1'b1;
        data_in     = 16'hA53C;
        tick(2);
        check("t1_valid_edge2", 32'(out_valid), 32'd0);
        tick(1);
        check("t1_valid_edge3", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'h0000A53C);
        tick(1);
        check("t1_empty_after_pop", 32'(out_valid), 32'd0);
        slow_clk_in = 1'b0;
        tick(4);
        check("t1_too_fast", 32'(too_fast), 32'd0);

        // Test 2: overflow on 5th word, then drain 1..4
        out_ready = 1'b0;
        slow_cycle(16'd1);
        slow_cycle(16'd2);
        slow_cycle(16'd3);
        slow_cycle(16'd4);
        check("t2_no_ovf_at_full", 32'(overflow), 32'd0);
        slow_cycle(16'd5);
        check("t2_overflow", 32'(overflow), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            check("t2_drain_valid", 32'(out_valid), 32'd1);
            check("t2_drain_data", 32'(out_data), 32'(k));
            out_ready = 1'b1;
            tick(1);
            out_ready = 1'b0;
        end
        check("t2_empty", 32'(out_valid), 32'd0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("t2_clr", 32'(overflow), 32'd0);

        // Test 3: push accepted when full if popped in the same cycle
        slow_cycle(16'd5);
        slow_cycle(16'd6);
        slow_cycle(16'd7);
        slow_cycle(16'd8);
        slow_clk_in = 1'b1;
        data_in     = 16'd9;
        tick(2);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("t3_no_overflow", 32'(overflow), 32'd0);
        tick(1);
        slow_clk_in = 1'b0;
        tick(4);
        check("t3_no_overflow_late", 32'(overflow), 32'd0);
        for (int k = 6; k <= 9; k++) begin
            check("t3_drain_data", 32'(out_data), 32'(k));
            out_ready = 1'b1;
            tick(1);
            out_ready = 1'b0;
        end
        check("t3_empty", 32'(out_valid), 32'd0);

        // Test 6: overflow set wins over simultaneous clr_err
        slow_cycle(16'd10);
        slow_cycle(16'd11);
        slow_cycle(16'd12);
        slow_cycle(16'd13);
        slow_clk_in = 1'b1;
        data_in     = 16'd14;
        tick(2);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("t6_set_beats_clr", 32'(overflow), 32'd1);
        check("t6_head_kept", 32'(out_data), 32'd10);
        tick(1);
        slow_clk_in = 1'b0;
        tick(4);

        // Test 4: reset mid-stream with slow_clk_in high
        slow_clk_in = 1'b1;
        data_in     = 16'h5555;
        tick(1);
        reset_n = 1'b0;
        #1;
        check("t4_valid_async", 32'(out_valid), 32'd0);
        check("t4_data_async", 32'(out_data), 32'd0);
        check("t4_overflow_async", 32'(overflow), 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(6);
        check("t4_no_capture_high", 32'(out_valid), 32'd0);
        slow_clk_in = 1'b0;
        tick(4);
        check("t4_no_capture_low", 32'(out_valid), 32'd0);
        slow_cycle(16'h77AA);
        check("t4_fresh_valid", 32'(out_valid), 32'd1);
        check("t4_fresh_data", 32'(out_data), 32'h000077AA);
        out_ready = 1'b1;
        tick(1);
        check("t4_fresh_pop", 32'(out_valid), 32'd0);

        // Test 5: slow period of 6 fast cycles after a clean reset
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(3);
`ifdef SLOW_TO_FAST_PERIOD_MON_EN
        exp_tf = 1'b1;
`else
        exp_tf = 1'b0;
`endif
        slow_clk_in = 1'b1;
        data_in     = 16'h0101;
        tick(3);
        slow_clk_in = 1'b0;
        tick(3);
        check("t5_first_edge", 32'(too_fast), 32'd0);
        slow_clk_in = 1'b1;
        data_in     = 16'h0202;
        tick(3);
        slow_clk_in = 1'b0;
        tick(3);
        check("t5_second_edge", 32'(too_fast), 32'(exp_tf));
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("t5_clr", 32'(too_fast), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
